iram_boot_loader: RTL and testbench

Hardware writer for the instruction memory. Replaces the simulation-only firmware preload in the RISCV_lite system.
- Receives a byte stream (valid/ready) carrying a length header, little-endian 32-bit words and an XOR checksum.
- Writes each assembled word into the ram_mem IRAM write port at consecutive word addresses from 0.
- Holds the core in reset until a checksum-verified load completes.

---
 rtl/boot_loader_pkg.sv | 17 +
 rtl/iram_boot_loader.sv | 171 +++++++++++++++++
 tb/tb_iram_boot_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the IRAM boot loader: FSM state encoding
// and the stream framing sizes.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHECK,
        DONE,
        ERR
    } boot_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/iram_boot_loader.sv
// Byte-stream loader for the instruction RAM: length header, LE words, XOR checksum.
// Writes words from address 0 and releases the core reset only after a verified load.
module iram_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic                  core_reset_n,
    output logic                  done,
    output logic                  error
);

    // One extra bit so a full-capacity load can count to 2**ADDR_WIDTH without wrapping.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [16:0]      N_MAX     = 17'(2 ** ADDR_WIDTH);
    localparam logic [1:0]       LAST_BYTE = 2'(WORD_BYTES - 1);

    boot_state_t           state_reg, state_next;
    logic [7:0]            n_lo_reg, n_lo_next;
    logic [CNT_W-1:0]      n_reg, n_next;
    logic [CNT_W-1:0]      word_cnt_reg, word_cnt_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [7:0]            csum_reg, csum_next;
    logic                  mem_write_reg, mem_write_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [31:0]           mem_data_reg, mem_data_next;
    logic                  in_ready_reg, in_ready_next;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;
    logic                  core_reset_n_reg, core_reset_n_next;

    logic                  accept;
    logic [15:0]           hdr_n;
    logic [23:0]           asm_low;

    assign accept = in_valid && in_ready_reg;
    assign hdr_n  = {in_data, n_lo_reg};

    // Lower three bytes of the word being assembled; the top byte comes
    // straight from the stream when the word completes.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_asm
            logic [7:0] lane_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if (accept && state_reg == DATA && byte_cnt_reg == 2'(gi)) begin
                    lane_reg <= in_data;
                end
            end
            assign asm_low[8*gi +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= HDR_LO;
            n_lo_reg         <= '0;
            n_reg            <= '0;
            word_cnt_reg     <= '0;
            byte_cnt_reg     <= '0;
            csum_reg         <= '0;
            mem_write_reg    <= 1'b0;
            mem_addr_reg     <= '0;
            mem_data_reg     <= '0;
            in_ready_reg     <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            core_reset_n_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            n_lo_reg         <= n_lo_next;
            n_reg            <= n_next;
            word_cnt_reg     <= word_cnt_next;
            byte_cnt_reg     <= byte_cnt_next;
            csum_reg         <= csum_next;
            mem_write_reg    <= mem_write_next;
            mem_addr_reg     <= mem_addr_next;
            mem_data_reg     <= mem_data_next;
            in_ready_reg     <= in_ready_next;
            done_reg         <= done_next;
            error_reg        <= error_next;
            core_reset_n_reg <= core_reset_n_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        n_lo_next      = n_lo_reg;
        n_next         = n_reg;
        word_cnt_next  = word_cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        csum_next      = csum_reg;
        mem_write_next = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_data_next  = mem_data_reg;

        unique case (state_reg)
            HDR_LO: begin
                if (accept) begin
                    n_lo_next  = in_data;
                    state_next = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    if ({1'b0, hdr_n} > N_MAX) begin
                        state_next = ERR;
                    end else if (hdr_n == 16'd0) begin
                        state_next = CHECK;
                    end else begin
                        n_next     = hdr_n[CNT_W-1:0];
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_next     = csum_reg ^ in_data;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        mem_write_next = 1'b1;
                        mem_data_next  = {in_data, asm_low};
                        mem_addr_next  = word_cnt_reg[ADDR_WIDTH-1:0];
                        word_cnt_next  = word_cnt_reg + CNT_ONE;
                        if (word_cnt_reg == n_reg - CNT_ONE) begin
                            state_next = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_next = (in_data == csum_reg) ? DONE : ERR;
                end
            end
            DONE:    state_next = DONE;
            ERR:     state_next = ERR;
            default: state_next = HDR_LO;
        endcase
    end

    // Status flags lag the terminal state by one cycle, which keeps done
    // strictly after the final write pulse.
    always_comb begin
        in_ready_next     = (state_next == HDR_LO) || (state_next == HDR_HI) ||
                            (state_next == DATA)   || (state_next == CHECK);
        done_next         = (state_reg == DONE);
        core_reset_n_next = (state_reg == DONE);
        error_next        = (state_reg == ERR);
    end

    assign in_ready     = in_ready_reg;
    assign mem_write    = mem_write_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_data     = mem_data_reg;
    assign done         = done_reg;
    assign error        = error_reg;
    assign core_reset_n = core_reset_n_reg;

endmodule

// File: tb/tb_iram_boot_loader.sv
// Bench for iram_boot_loader: table of byte streams checked against a
// stream-level model, plus hand sequences for completion timing and mid-load reset.
module tb_iram_boot_loader;
    import boot_loader_pkg::*;

    localparam int AW    = 7;
    localparam int DEPTH = 2 ** AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          core_reset_n;
    logic          done;
    logic          error;

    always #5 clock = ~clock;

    iram_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .core_reset_n (core_reset_n),
        .done         (done),
        .error        (error)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        int start;
        int max_gap;
        int exp_writes;
        bit exp_done;
        bit exp_err;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] pool[$];
    vec_t       tbl[$];
    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [31:0] iram [DEPTH];
    logic       prev_wr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // IRAM stand-in and write-pulse shape checks.
    always @(negedge clock) begin
        if (mem_write) begin
            check("write_pulse_single_cycle", prev_wr, 1'b0);
            check("done_low_during_write", done, 1'b0);
            got_q.push_back('{addr: mem_addr, data: mem_data});
            iram[mem_addr] = mem_data;
        end
        prev_wr = mem_write;
    end

    // Stream-level reference: parse header, words and checksum directly.
    task automatic model(input int s, output bit e_done, output bit e_err, output int n_acc);
        int n;
        logic [7:0]  cs;
        logic [31:0] word;
        exp_q.delete();
        n = int'(pool[s]) | (int'(pool[s+1]) << 8);
        if (n > DEPTH) begin
            e_done = 1'b0;
            e_err  = 1'b1;
            n_acc  = HDR_BYTES;
            return;
        end
        cs = 8'h00;
        for (int w = 0; w < n; w++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                word = word | (32'(pool[s + HDR_BYTES + 4*w + k]) << (8*k));
                cs   = cs ^ pool[s + HDR_BYTES + 4*w + k];
            end
            exp_q.push_back('{addr: AW'(w), data: word});
        end
        e_done = (pool[s + HDR_BYTES + 4*n] == cs);
        e_err  = !e_done;
        n_acc  = HDR_BYTES + 4*n + 1;
    endtask

    task automatic send(input int s, input int count, input int max_gap);
        int waits;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                in_valid = 1'b0;
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            in_data  = pool[s + i];
            waits = 0;
            while (!in_ready && waits < 20) begin
                @(posedge clock); #1;
                waits++;
            end
            if (!in_ready) begin
                check("in_ready_for_byte", in_ready, 1'b1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_data", mem_data, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_core_reset_n", core_reset_n, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs();
        reset = 1'b0;
    endtask

    task automatic run_body(input int idx, input vec_t v);
        bit md, me;
        int nacc, nchk;
        got_q.delete();
        model(v.start, md, me, nacc);
        send(v.start, nacc, v.max_gap);
        // Just after the final accepted byte: flags not yet up, stream closed.
        check("flag_done_not_yet", done, 1'b0);
        check("flag_error_not_yet", error, 1'b0);
        check("in_ready_closed", in_ready, 1'b0);
        @(posedge clock); #1;
        check("final_done", done, v.exp_done);
        check("final_error", error, v.exp_err);
        check("final_core_reset_n", core_reset_n, v.exp_done);
        check("final_in_ready", in_ready, 1'b0);
        check("write_count", got_q.size(), v.exp_writes);
        check("write_count_model", got_q.size(), exp_q.size());
        nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++) begin
            check("write_addr", got_q[i].addr, exp_q[i].addr);
            check("write_data", got_q[i].data, exp_q[i].data);
            check("iram_contents", iram[exp_q[i].addr], exp_q[i].data);
        end
        repeat (3) @(posedge clock);
        #1;
        check("held_done", done, v.exp_done);
        check("held_error", error, v.exp_err);
        check("held_write_count", got_q.size(), v.exp_writes);
        $display("[TB] vec %0d: start=%0d bytes=%0d writes=%0d done=%0b error=%0b core_reset_n=%0b",
                 idx, v.start, nacc, got_q.size(), done, error, core_reset_n);
    endtask

    function automatic int add_stream(input logic [7:0] hdr_lo, input logic [7:0] hdr_hi,
                                      input int nbytes, input bit corrupt);
        int s;
        logic [7:0] cs, b;
        s  = pool.size();
        cs = 8'h00;
        pool.push_back(hdr_lo);
        pool.push_back(hdr_hi);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom_range(255, 0));
            cs = cs ^ b;
            pool.push_back(b);
        end
        pool.push_back(corrupt ? ~cs : cs);
        return s;
    endfunction

    initial begin
        logic [7:0] s1 [11];
        int s1_start, s2_start, s3_start, s4a_start, s4b_start, s, n;
        bit md, me;
        int nacc;
        vec_t v;

        s1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h31};
        s1_start = pool.size();
        foreach (s1[i]) pool.push_back(s1[i]);
        s2_start = pool.size();
        for (int i = 0; i < 10; i++) pool.push_back(s1[i]);
        pool.push_back(8'h30);
        s3_start = pool.size();
        pool.push_back(8'h00); pool.push_back(8'h00); pool.push_back(8'h00);
        s4a_start = pool.size();
        pool.push_back(8'h81); pool.push_back(8'h00);
        s4b_start = add_stream(8'h80, 8'h00, 4 * DEPTH, 1'b0);

        tbl.push_back('{start: s1_start,  max_gap: 0, exp_writes: 2,     exp_done: 1'b1, exp_err: 1'b0});
        tbl.push_back('{start: s2_start,  max_gap: 0, exp_writes: 2,     exp_done: 1'b0, exp_err: 1'b1});
        tbl.push_back('{start: s3_start,  max_gap: 0, exp_writes: 0,     exp_done: 1'b1, exp_err: 1'b0});
        tbl.push_back('{start: s4a_start, max_gap: 0, exp_writes: 0,     exp_done: 1'b0, exp_err: 1'b1});
        tbl.push_back('{start: s4b_start, max_gap: 0, exp_writes: DEPTH, exp_done: 1'b1, exp_err: 1'b0});
        tbl.push_back('{start: s1_start,  max_gap: 5, exp_writes: 2,     exp_done: 1'b1, exp_err: 1'b0});

        // Random streams: short loads, sometimes with a bad checksum, and an oversized header.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(12, 1);
            s = add_stream(8'(n), 8'h00, 4 * n, 1'($urandom_range(1, 0)));
            model(s, md, me, nacc);
            v = '{start: s, max_gap: $urandom_range(3, 0), exp_writes: n, exp_done: md, exp_err: me};
            tbl.push_back(v);
        end
        n = $urandom_range(65535, DEPTH + 1);
        s = pool.size();
        pool.push_back(8'(n)); pool.push_back(8'(n >> 8));
        tbl.push_back('{start: s, max_gap: 2, exp_writes: 0, exp_done: 1'b0, exp_err: 1'b1});

        repeat (2) @(posedge clock);
        #1;
        foreach (tbl[i]) begin
            do_reset();
            run_body(i, tbl[i]);
        end

        // Reset six bytes into scenario 1, then resend it without another reset.
        do_reset();
        got_q.delete();
        send(s1_start, 6, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs();
        check("midreset_writes_before", got_q.size(), 1);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("midreset_no_writes_after", got_q.size(), 1);
        run_body(tbl.size(), tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
